// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen
//   Front end for a T flip-flop. The block has two sources of toggle pulses:
//   - a debounced push-button, which gives one pulse per accepted press
//   - a programmable divider, which gives periodic pulses
//   It also reports the debounced button level and a wrapping count of the
//   pulses it has issued.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   btn_in       raw button level; asynchronous to clk and may bounce
//   mode         0 = button mode, 1 = periodic mode
//   period       pulse interval in periodic mode, in clk cycles (0 = off)
//   t_out        registered single-cycle toggle pulse (drives T of the flop)
//   btn_stable   registered debounced button level
//   pulse_count  number of cycles with t_out high, modulo 256
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIV_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_in,
  input  logic                 mode,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 t_out,
  output logic                 btn_stable,
  output logic [7:0]           pulse_count
);

  // Counter width is at least one bit, so that DEBOUNCE_CYCLES = 1 still works.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 sync1_r;
  logic                 sync2_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic                 stable_s;
  logic                 press_s;
  logic [DIV_WIDTH-1:0] div_cnt_r;
  logic [DIV_WIDTH-1:0] div_cnt_s;
  logic [DIV_WIDTH-1:0] period_m1_s;
  logic                 t_s;

  // Debounce next-state logic. The FSM sees only the synchronized level.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    stable_s = btn_stable;
    press_s  = 1'b0;
    case (state_r)
      IDLE_LOW: begin
        if (sync2_r) begin
          state_s = WAIT_HIGH;
          cnt_s   = '0;
        end else begin
          state_s = IDLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_r) begin
          state_s = IDLE_LOW;
        end else if (cnt_r == CNT_LAST) begin
          state_s  = IDLE_HIGH;
          stable_s = 1'b1;
          press_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2_r) begin
          state_s = WAIT_LOW;
          cnt_s   = '0;
        end else begin
          state_s = IDLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (sync2_r) begin
          state_s = IDLE_HIGH;
        end else if (cnt_r == CNT_LAST) begin
          state_s  = IDLE_LOW;
          stable_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE_LOW;
        cnt_s   = '0;
      end
    endcase
  end

  // Pulse source selection and the periodic divider.
  // The ">=" compare means that lowering period in the middle of a count
  // gives a pulse on the next edge, instead of letting the counter run past
  // the new period.
  always_comb begin
    period_m1_s = period - DIV_WIDTH'(1);
    div_cnt_s   = '0;
    t_s         = 1'b0;
    if (mode) begin
      if (period == '0) begin
        div_cnt_s = '0;
        t_s       = 1'b0;
      end else if (div_cnt_r >= period_m1_s) begin
        div_cnt_s = '0;
        t_s       = 1'b1;
      end else begin
        div_cnt_s = div_cnt_r + DIV_WIDTH'(1);
        t_s       = 1'b0;
      end
    end else begin
      t_s = press_s;
    end
  end

  // State, synchronizer, divider and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE_LOW;
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      cnt_r       <= '0;
      div_cnt_r   <= '0;
      t_out       <= 1'b0;
      btn_stable  <= 1'b0;
      pulse_count <= 8'd0;
    end else begin
      state_r    <= state_s;
      sync1_r    <= btn_in;
      sync2_r    <= sync1_r;
      cnt_r      <= cnt_s;
      div_cnt_r  <= div_cnt_s;
      t_out      <= t_s;
      btn_stable <= stable_s;
      if (t_s) begin
        pulse_count <= pulse_count + 8'd1;
      end else begin
        pulse_count <= pulse_count;
      end
    end
  end

endmodule
